// File: rtl/freq_avg_bcd_if.sv
// Bus between the frequency averager and its memory / readout neighbours.
// The master side issues start and returns memory read data; the slave side
// (the averager) drives the read address and publishes the results.
interface freq_avg_bcd_if #(
  parameter int DATA_WIDTH = 26,
  parameter int ADDR_WIDTH = 2,
  parameter int DIGITS     = 8
);
  logic                    start;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    busy;
  logic                    done;
  logic [DATA_WIDTH-1:0]   avg_freq;
  logic [4*DIGITS-1:0]     bcd;

  modport master (
    output start, data_r,
    input  addr_r, busy, done, avg_freq, bcd
  );

  modport slave (
    input  start, data_r,
    output addr_r, busy, done, avg_freq, bcd
  );
endinterface

// File: rtl/freq_avg_bcd.sv
// Frequency averager: reads every entry of the frequency register file, sums
// them, divides by the entry count with a shift, then converts the mean to
// packed BCD using one double-dabble iteration per clock.
module freq_avg_bcd #(
  parameter int DATA_WIDTH = 26,
  parameter int ADDR_WIDTH = 2,
  parameter int DIGITS     = 8
) (
  input  logic               clk,
  input  logic               reset,
  freq_avg_bcd_if.slave      bus
);

  localparam int ENTRIES = 2 ** ADDR_WIDTH;
  localparam int SUM_W   = DATA_WIDTH + ADDR_WIDTH;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int SR_W    = BCD_W + DATA_WIDTH;
  localparam int CNT_W   = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACC,
    S_AVG,
    S_CONV,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DATA_WIDTH-1:0] avg_q, avg_d;
  logic [SR_W-1:0]       sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] avg_freq_q, avg_freq_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [SR_W-1:0]       sr_adj;
  logic [SR_W-1:0]       sr_shift;

  // State and datapath registers; reset abandons any pass in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      sum_q      <= '0;
      avg_q      <= '0;
      sr_q       <= '0;
      cnt_q      <= '0;
      avg_freq_q <= '0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      avg_q      <= avg_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      avg_freq_q <= avg_freq_d;
      bcd_q      <= bcd_d;
    end
  end

  // Sequencing: two cycles per entry (settle, accumulate), average, convert, publish.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sum_d      = sum_q;
    avg_d      = avg_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    avg_freq_d = avg_freq_q;
    bcd_d      = bcd_q;

    sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_adj[DATA_WIDTH + 4*i +: 4] >= 4'd5) begin
        sr_adj[DATA_WIDTH + 4*i +: 4] = sr_adj[DATA_WIDTH + 4*i +: 4] + 4'd3;
      end
    end
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (bus.start) begin
          sum_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_ACC;
      end
      S_ACC: begin
        sum_d = sum_q + SUM_W'(bus.data_r);
        if (addr_q == ADDR_WIDTH'(ENTRIES - 1)) begin
          state_d = S_AVG;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_AVG: begin
        avg_d   = sum_q[SUM_W-1:ADDR_WIDTH];
        sr_d    = {{BCD_W{1'b0}}, sum_q[SUM_W-1:ADDR_WIDTH]};
        cnt_d   = '0;
        addr_d  = '0;
        state_d = S_CONV;
      end
      S_CONV: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          avg_freq_d = avg_q;
          bcd_d      = sr_shift[SR_W-1 -: BCD_W];
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.addr_r   = addr_q;
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.avg_freq = avg_freq_q;
  assign bus.bcd      = bcd_q;

endmodule

// File: tb/tb_freq_avg_bcd.sv
// Bench for freq_avg_bcd: a behavioural memory answers reads, each requested
// pass pushes its expected mean/BCD to a queue, and a monitor pops on done.
module tb_freq_avg_bcd;

  localparam int DW = 26;
  localparam int AW = 2;
  localparam int ND = 8;

  typedef struct packed {
    logic [DW-1:0]   avg;
    logic [4*ND-1:0] bcd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  logic [DW-1:0]   mem [4];
  logic [AW-1:0]   addr_log [8];
  int              busy_cycles;
  logic            done_busy;
  logic [DW-1:0]   got_avg;
  logic [4*ND-1:0] got_bcd;

  always #5 clk = ~clk;

  freq_avg_bcd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIGITS(ND)) bus ();

  freq_avg_bcd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIGITS(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.data_r = mem[bus.addr_r];

  // Decimal reference conversion by repeated division.
  function automatic logic [4*ND-1:0] to_bcd(input logic [DW-1:0] v);
    logic [4*ND-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic push_expected();
    logic [DW+AW-1:0] s;
    exp_t e;
    s = '0;
    for (int i = 0; i < 4; i++) s = s + (DW+AW)'(mem[i]);
    e.avg = s[DW+AW-1:AW];
    e.bcd = to_bcd(e.avg);
    sb.push_back(e);
  endtask

  task automatic load_mem(input logic [DW-1:0] a, b, c, d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_done avg=%0d bcd=%h", bus.avg_freq, bus.bcd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.avg_freq !== e.avg || bus.bcd !== e.bcd) begin
          tests_failed++;
          $display("[TB] FAIL sb_result got avg=%0d bcd=%h want avg=%0d bcd=%h",
                   bus.avg_freq, bus.bcd, e.avg, e.bcd);
        end
      end
    end
  end

  // One pass with a single-cycle start pulse; returns done latency or -1.
  task automatic run_pass(output int lat);
    lat = -1;
    busy_cycles = 0;
    done_busy = 1'bx;
    push_expected();
    bus.start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (k <= 8) addr_log[k-1] = bus.addr_r;
      if (bus.done === 1'b1) begin
        lat = k;
        done_busy = bus.busy;
        got_avg = bus.avg_freq;
        got_bcd = bus.bcd;
        break;
      end
      if (bus.busy === 1'b1) busy_cycles++;
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    load_mem('0, '0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    tests_run++;
    if (bus.addr_r !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_addr got %0d want 0", bus.addr_r); end
    tests_run++;
    if (bus.avg_freq !== '0) begin tests_failed++; $display("[TB] FAIL reset_avg got %0d want 0", bus.avg_freq); end
    tests_run++;
    if (bus.bcd !== '0) begin tests_failed++; $display("[TB] FAIL reset_bcd got %h want 0", bus.bcd); end
    reset = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    logic [AW-1:0] want_addr [8];
    want_addr = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    load_mem(26'd1000, 26'd1000, 26'd1000, 26'd1000);
    run_pass(lat);
    tests_run++;
    if (lat != 36) begin tests_failed++; $display("[TB] FAIL basic_latency got %0d want 36", lat); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (addr_log[i] !== want_addr[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_addr[%0d] got %0d want %0d", i, addr_log[i], want_addr[i]);
      end
    end
    tests_run++;
    if (busy_cycles != 35) begin tests_failed++; $display("[TB] FAIL basic_busy_cycles got %0d want 35", busy_cycles); end
    tests_run++;
    if (done_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy_at_done got %b want 0", done_busy); end
    tests_run++;
    if (got_avg !== 26'd1000) begin tests_failed++; $display("[TB] FAIL basic_avg got %0d want 1000", got_avg); end
    tests_run++;
    if (got_bcd !== 32'h0000_1000) begin tests_failed++; $display("[TB] FAIL basic_bcd got %h want 00001000", got_bcd); end
  endtask

  task automatic test_values();
    logic [DW-1:0]   va [4][4];
    logic [DW-1:0]   want_avg [4];
    logic [4*ND-1:0] want_bcd [4];
    int lat;
    va[0] = '{26'd1, 26'd2, 26'd3, 26'd4};
    va[1] = '{26'd50_000_000, 26'd50_000_000, 26'd50_000_000, 26'd50_000_000};
    va[2] = '{26'd67_108_863, 26'd67_108_863, 26'd67_108_863, 26'd67_108_863};
    va[3] = '{26'd0, 26'd0, 26'd0, 26'd7};
    want_avg = '{26'd2, 26'd50_000_000, 26'd67_108_863, 26'd1};
    want_bcd = '{32'h0000_0002, 32'h5000_0000, 32'h6710_8863, 32'h0000_0001};
    for (int t = 0; t < 4; t++) begin
      load_mem(va[t][0], va[t][1], va[t][2], va[t][3]);
      run_pass(lat);
      tests_run++;
      if (lat != 36) begin tests_failed++; $display("[TB] FAIL values%0d_latency got %0d want 36", t, lat); end
      tests_run++;
      if (got_avg !== want_avg[t]) begin
        tests_failed++;
        $display("[TB] FAIL values%0d_avg got %0d want %0d", t, got_avg, want_avg[t]);
      end
      tests_run++;
      if (got_bcd !== want_bcd[t]) begin
        tests_failed++;
        $display("[TB] FAIL values%0d_bcd got %h want %h", t, got_bcd, want_bcd[t]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    int first_k;
    load_mem(26'd123, 26'd456, 26'd789, 26'd1011);
    push_expected();
    dones = 0;
    first_k = -1;
    bus.start = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (k == 10) bus.start = 1'b1;
      if (k == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (first_k < 0) first_k = k;
      end
    end
    tests_run++;
    if (dones != 1) begin tests_failed++; $display("[TB] FAIL ignore_done_count got %0d want 1", dones); end
    tests_run++;
    if (first_k != 36) begin tests_failed++; $display("[TB] FAIL ignore_latency got %0d want 36", first_k); end
  endtask

  task automatic test_back_to_back();
    int k1;
    int k2;
    load_mem(26'd9, 26'd99, 26'd999, 26'd9999);
    push_expected();
    push_expected();
    k1 = -1;
    k2 = -1;
    bus.start = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk); #1;
      if (bus.done === 1'b1) begin
        if (k1 < 0) k1 = k;
        else begin
          k2 = k;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    tests_run++;
    if (k1 != 36) begin tests_failed++; $display("[TB] FAIL b2b_first got %0d want 36", k1); end
    tests_run++;
    if (k2 - k1 != 37) begin tests_failed++; $display("[TB] FAIL b2b_gap got %0d want 37", k2 - k1); end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset_mid_pass();
    int dones;
    int lat;
    load_mem(26'd40, 26'd40, 26'd40, 26'd40);
    push_expected();
    bus.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (k == 1) bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_busy got %b want 0", bus.busy); end
    tests_run++;
    if (bus.avg_freq !== '0) begin tests_failed++; $display("[TB] FAIL midrst_avg got %0d want 0", bus.avg_freq); end
    tests_run++;
    if (bus.bcd !== '0) begin tests_failed++; $display("[TB] FAIL midrst_bcd got %h want 0", bus.bcd); end
    tests_run++;
    if (bus.addr_r !== 2'd0) begin tests_failed++; $display("[TB] FAIL midrst_addr got %0d want 0", bus.addr_r); end
    reset = 1'b0;
    sb.delete();
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk); #1;
    end
    tests_run++;
    if (dones != 0) begin tests_failed++; $display("[TB] FAIL midrst_no_done got %0d want 0", dones); end
    load_mem(26'd2, 26'd4, 26'd6, 26'd8);
    run_pass(lat);
    tests_run++;
    if (lat != 36) begin tests_failed++; $display("[TB] FAIL midrst_recover_latency got %0d want 36", lat); end
    tests_run++;
    if (got_avg !== 26'd5) begin tests_failed++; $display("[TB] FAIL midrst_recover_avg got %0d want 5", got_avg); end
  endtask

  initial begin
    bus.start = 1'b0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_pass();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
